// File: rtl/uart_pkg.sv
// Shared UART definitions: arbiter state encoding, default byte width,
// watchdog width and the baud constants used by the TX/RX cores.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_DONE = 2'd2
    } arb_state_e;

    localparam int DEF_DATA_W = 8;
    localparam int WDOG_W     = 16;
    localparam int CLOCK_FREQ = 50000000;
    localparam int BAUD_RATE  = 115200;
    localparam int BAUD_DIV   = CLOCK_FREQ / BAUD_RATE;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first set bit of req_mask searching
// upward from rr_ptr+1, wrapping modulo NUM_REQ.
module uart_rr_pick
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_mask,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [IDX_W-1:0]   winner,
    output logic               any_valid
);

    int               pos_s;
    logic [IDX_W-1:0] cand_s;
    logic             found_s;

    assign any_valid = |req_mask;

    // Walk the candidates in priority order; the first eligible one wins.
    always_comb begin
        pos_s   = 0;
        cand_s  = '0;
        found_s = 1'b0;
        winner  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            pos_s = int'(rr_ptr) + k;
            if (pos_s >= NUM_REQ) begin
                pos_s = pos_s - NUM_REQ;
            end else begin
                pos_s = pos_s;
            end
            cand_s = IDX_W'(pos_s);
            if (!found_s && req_mask[cand_s]) begin
                found_s = 1'b1;
                winner  = cand_s;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter with a completion watchdog.
// Optional burst lock (keeps multi-byte messages contiguous): UART_TX_ARB_LOCK_EN.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int TIMEOUT_CYC = 8192
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       tx_start,
    output logic [DATA_W-1:0]          tx_data,
    input  logic                       tx_done,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       arb_busy,
    output logic                       timeout_err
);

    localparam int                IDX_W     = $clog2(NUM_REQ);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYC - 1);

    arb_state_e          state_r, state_nx_s;
    logic [IDX_W-1:0]    rr_ptr_r, rr_ptr_nx_s, grant_r, grant_nx_s, winner_s;
    logic [NUM_REQ-1:0]  elig_s, ready_r, ready_nx_s;
    logic [DATA_W-1:0]   data_r, data_nx_s;
    logic [DATA_W-1:0]   req_bytes_s [NUM_REQ];
    logic [WDOG_W-1:0]   wdog_r, wdog_nx_s;
    logic                any_s, start_r, start_nx_s, timeout_r, timeout_nx_s, busy_r;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_bytes
        assign req_bytes_s[g] = req_data[g*DATA_W +: DATA_W];
    end

`ifdef UART_TX_ARB_LOCK_EN
    logic lock_r, lock_nx_s, last_r, last_nx_s;
    // While locked only the requester that owns the burst may win.
    assign elig_s = lock_r ? (req_valid & (NUM_REQ'(1) << grant_r)) : req_valid;
`else
    logic unused_last_s;
    assign elig_s        = req_valid;
    assign unused_last_s = ^req_last;
`endif

    uart_rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
        .req_mask  (elig_s),
        .rr_ptr    (rr_ptr_r),
        .winner    (winner_s),
        .any_valid (any_s)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state decode; tx_done outranks a simultaneous watchdog expiry.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (any_s) begin
                    state_nx_s = ST_ISSUE;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_ISSUE: state_nx_s = ST_WAIT_DONE;
            ST_WAIT_DONE: begin
                if (tx_done || (wdog_r == WDOG_LAST)) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_WAIT_DONE;
                end
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs, pointer, watchdog and lock.
    always_comb begin
        ready_nx_s   = '0;
        start_nx_s   = 1'b0;
        timeout_nx_s = 1'b0;
        data_nx_s    = data_r;
        grant_nx_s   = grant_r;
        rr_ptr_nx_s  = rr_ptr_r;
        wdog_nx_s    = wdog_r;
`ifdef UART_TX_ARB_LOCK_EN
        lock_nx_s    = lock_r;
        last_nx_s    = last_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (any_s) begin
                    ready_nx_s  = NUM_REQ'(1) << winner_s;
                    start_nx_s  = 1'b1;
                    data_nx_s   = req_bytes_s[winner_s];
                    grant_nx_s  = winner_s;
                    rr_ptr_nx_s = winner_s;
`ifdef UART_TX_ARB_LOCK_EN
                    last_nx_s   = req_last[winner_s];
                    lock_nx_s   = lock_r | ~req_last[winner_s];
`endif
                end else begin
                    ready_nx_s = '0;
                end
            end
            ST_ISSUE: wdog_nx_s = '0;
            ST_WAIT_DONE: begin
                if (tx_done) begin
`ifdef UART_TX_ARB_LOCK_EN
                    lock_nx_s = lock_r & ~last_r;
`endif
                    wdog_nx_s = wdog_r;
                end else if (wdog_r == WDOG_LAST) begin
                    timeout_nx_s = 1'b1;
`ifdef UART_TX_ARB_LOCK_EN
                    lock_nx_s    = 1'b0;
`endif
                end else begin
                    wdog_nx_s = wdog_r + WDOG_W'(1);
                end
            end
            default: wdog_nx_s = '0;
        endcase
    end

    // Datapath and output registers; reset puts requester 0 first in line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_r   <= '0;
            start_r   <= 1'b0;
            timeout_r <= 1'b0;
            data_r    <= '0;
            grant_r   <= '0;
            rr_ptr_r  <= IDX_W'(NUM_REQ - 1);
            wdog_r    <= '0;
            busy_r    <= 1'b0;
        end else begin
            ready_r   <= ready_nx_s;
            start_r   <= start_nx_s;
            timeout_r <= timeout_nx_s;
            data_r    <= data_nx_s;
            grant_r   <= grant_nx_s;
            rr_ptr_r  <= rr_ptr_nx_s;
            wdog_r    <= wdog_nx_s;
            busy_r    <= (state_nx_s != ST_IDLE);
        end
    end

`ifdef UART_TX_ARB_LOCK_EN
    // Burst lock state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_r <= 1'b0;
            last_r <= 1'b0;
        end else begin
            lock_r <= lock_nx_s;
            last_r <= last_nx_s;
        end
    end
`endif

    assign req_ready   = ready_r;
    assign tx_start    = start_r;
    assign tx_data     = data_r;
    assign grant_id    = grant_r;
    assign arb_busy    = busy_r;
    assign timeout_err = timeout_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (NUM_REQ=4, DATA_W=8).
module tb_uart_tx_arbiter;

    localparam int NR = 4;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [NR-1:0] req_valid, req_last, req_ready;
    logic [NR*DW-1:0] req_data;
    logic          tx_start, tx_done, arb_busy, timeout_err;
    logic [DW-1:0] tx_data;
    logic [1:0]    grant_id;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] data;
        logic [1:0]  grant;
        logic [7:0]  byte_exp;
    } vec_t;

    vec_t tbl [9];

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .TIMEOUT_CYC(8192)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_done     (tx_done),
        .grant_id    (grant_id),
        .arb_busy    (arb_busy),
        .timeout_err (timeout_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tx_start === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Called at the negedge of the tx_start cycle.
    task automatic finish_tx(input int gap);
        repeat (gap) @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        check("busy_after_done", arb_busy, 0);
    endtask

    logic [1:0] fair_exp [6];
    logic [1:0] lock_exp [5];
    logic [7:0] b1 [3];
    logic [7:0] l1 [3];
    logic [7:0] b0 [2];
    int         n0, n1;
    logic [1:0] eg;
    logic [7:0] eb;
    bit         ok, early;
    logic [31:0] fair_data;

    task automatic drive_lock_reqs();
        req_valid[1] = (n1 < 3);
        req_data[15:8] = (n1 < 3) ? b1[n1] : 8'h00;
        req_last[1] = (n1 < 3) ? l1[n1][0] : 1'b1;
        req_valid[0] = (n0 < 2);
        req_data[7:0] = (n0 < 2) ? b0[n0] : 8'h00;
        req_last[0] = 1'b1;
    endtask

    initial begin
        // rr_ptr evolves 2 -> 3,0,1,2,0,3,0,2,3 across this table
        tbl[0] = '{4'b1111, 32'hD3C2B1A0, 2'd3, 8'hD3};
        tbl[1] = '{4'b1111, 32'hD3C2B1A0, 2'd0, 8'hA0};
        tbl[2] = '{4'b1111, 32'hD3C2B1A0, 2'd1, 8'hB1};
        tbl[3] = '{4'b0101, 32'hD3C2B1A0, 2'd2, 8'hC2};
        tbl[4] = '{4'b0101, 32'hD3C2B1A0, 2'd0, 8'hA0};
        tbl[5] = '{4'b1000, 32'hD3C2B1A0, 2'd3, 8'hD3};
        tbl[6] = '{4'b0011, 32'h12345678, 2'd0, 8'h78};
        tbl[7] = '{4'b0100, 32'h12345678, 2'd2, 8'h34};
        tbl[8] = '{4'b1000, 32'h9ABCDEF0, 2'd3, 8'h9A};
        fair_exp = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd3};
`ifdef UART_TX_ARB_LOCK_EN
        lock_exp = '{2'd1, 2'd1, 2'd1, 2'd0, 2'd0};
`else
        lock_exp = '{2'd1, 2'd0, 2'd1, 2'd0, 2'd1};
`endif
        b1 = '{8'h11, 8'h12, 8'h13};
        l1 = '{8'h00, 8'h00, 8'h01};
        b0 = '{8'h01, 8'h02};

        req_valid = '0; req_data = '0; req_last = 4'hF; tx_done = 1'b0;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_outputs", {req_ready, tx_start, tx_data, grant_id, arb_busy, timeout_err}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single request from requester 2, done about 100 cycles later
        req_valid = 4'b0100; req_data = 32'h00A50000;
        @(negedge clk);
        check("single_ready", req_ready, 4'b0100);
        check("single_start", tx_start, 1);
        check("single_data", tx_data, 8'hA5);
        check("single_grant", grant_id, 2);
        check("single_busy", arb_busy, 1);
        req_valid = '0;
        @(negedge clk);
        check("single_start_pulse", {tx_start, req_ready}, 0);
        finish_tx(98);

        // Table of single grants, each completed before the next
        for (int i = 0; i < 9; i++) begin
            req_valid = tbl[i].valid; req_data = tbl[i].data;
            @(negedge clk);
            check($sformatf("tbl%0d_ready", i), req_ready, 4'b0001 << tbl[i].grant);
            check($sformatf("tbl%0d_start", i), tx_start, 1);
            check($sformatf("tbl%0d_grant", i), grant_id, tbl[i].grant);
            check($sformatf("tbl%0d_data", i), tx_data, tbl[i].byte_exp);
            req_valid = '0;
            finish_tx(1);
        end

        // Fairness with 0,1,3 held; start exactly 2 cycles after each done
        fair_data = 32'hD3C2B1A0;
        req_data = fair_data; req_valid = 4'b1011;
        @(negedge clk);
        check("fair_start0", tx_start, 1);
        check("fair_grant0", grant_id, fair_exp[0]);
        for (int i = 0; i < 6; i++) begin
            repeat (3 + i) @(negedge clk);
            tx_done = 1'b1;
            if (i == 5) req_valid = '0;
            @(negedge clk);
            tx_done = 1'b0;
            check("fair_idle", {arb_busy, tx_start}, 0);
            if (i < 5) begin
                @(negedge clk);
                check("fair_start", tx_start, 1);
                check("fair_grant", grant_id, fair_exp[i+1]);
                eg = fair_exp[i+1];
                eb = fair_data[eg*8 +: 8];
                check("fair_data", tx_data, eb);
            end
        end

        // Watchdog timeout, then pending requester 1 is served
        req_data = 32'h00006D5C; req_valid = 4'b0001;
        @(negedge clk);
        check("to_grant", grant_id, 0);
        req_valid = 4'b0010;
        early = 1'b0;
        repeat (8192) begin
            @(negedge clk);
            if (timeout_err !== 1'b0) early = 1'b1;
        end
        check("to_not_early", early, 0);
        @(negedge clk);
        check("to_pulse", timeout_err, 1);
        check("to_idle", arb_busy, 0);
        @(negedge clk);
        check("to_pulse_end", timeout_err, 0);
        check("to_next_start", tx_start, 1);
        check("to_next_grant", grant_id, 1);
        check("to_next_data", tx_data, 8'h6D);
        req_valid = '0;
        finish_tx(2);

        // tx_done coincident with watchdog expiry: done wins
        req_data = 32'h00770000; req_valid = 4'b0100;
        @(negedge clk);
        check("col_grant", grant_id, 2);
        req_valid = '0;
        repeat (8192) @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        check("col_no_timeout", timeout_err, 0);
        check("col_idle", arb_busy, 0);
        @(negedge clk);
        check("col_no_timeout_late", timeout_err, 0);

        // Stray done while idle
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        check("stray_state", {arb_busy, tx_start, req_ready, timeout_err}, 0);
        check("stray_hold", {grant_id, tx_data}, {2'd2, 8'h77});

        // Async reset in WAIT_DONE, then requester 0 has first priority
        req_data = 32'hD3C2B1A0; req_valid = 4'b1000;
        @(negedge clk);
        check("rst_pre_grant", grant_id, 3);
        req_valid = '0; req_data = '0;
        repeat (3) @(negedge clk);
        check("data_stable", tx_data, 8'hD3);
        check("rst_pre_busy", arb_busy, 1);
        #2 rst_n = 1'b0;
        #1 check("rst_async", {req_ready, tx_start, tx_data, grant_id, arb_busy, timeout_err}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        req_valid = 4'b1001; req_data = 32'hD3C2B1A0;
        @(negedge clk);
        check("rst_after_ready", req_ready, 4'b0001);
        check("rst_after_data", tx_data, 8'hA0);
        req_valid = '0;
        finish_tx(2);

        // Burst: requester 1 sends 3 bytes while requester 0 has 2 queued
        n0 = 0; n1 = 0;
        drive_lock_reqs();
        for (int k = 0; k < 5; k++) begin
            wait_start(ok);
            check("lock_start_seen", ok, 1);
            if (!ok) break;
            eg = lock_exp[k];
            eb = (eg == 2'd1) ? b1[n1 < 3 ? n1 : 0] : b0[n0 < 2 ? n0 : 0];
            check($sformatf("lock_grant%0d", k), grant_id, eg);
            check($sformatf("lock_data%0d", k), tx_data, eb);
            if (eg == 2'd1) n1++; else n0++;
            drive_lock_reqs();
            finish_tx(2);
        end
        req_valid = '0;
        @(negedge clk);
        check("lock_end_idle", arb_busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
